serial_code_lock: RTL and testbench

//  Parametrised serial combination lock for voting-booth access control.
//  - Compares CODE_LEN serial bits on B, qualified by B_valid, against a stored code.
//  - Reports a one-cycle Correct or Incorrect verdict per complete entry.
//  - Enforces a timed lockout after MAX_TRIES consecutive failures.
//  - Code is reloadable at runtime. Sits between the booth keypad deserialiser and the vote-enable logic.

---
 rtl/serial_code_lock.sv | 184 ++++++++++++++++++
 tb/tb_serial_code_lock.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_code_lock.sv
// ----------------------------------------------------------------------------
// serial_code_lock
//
// Serial combination lock for voting-booth access control. It sits between
// the booth keypad deserialiser and the vote-enable logic. CODE_LEN bits
// arrive MSB first on B, each qualified by B_valid, and are compared against
// a stored code. Every complete entry produces a one-cycle Correct or
// Incorrect pulse. After MAX_TRIES consecutive failures the lock refuses
// input for LOCKOUT_CYCLES cycles. The stored code can be replaced at
// runtime between entries.
//
// Ports
//   clock      in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   B_valid    in   B carries a code bit this cycle
//   B          in   serial code bit, MSB of code first
//   load_code  in   request to replace the stored code with new_code
//   new_code   in   replacement code, CODE_LEN bits
//   Correct    out  one-cycle pulse: the entry matched
//   Incorrect  out  one-cycle pulse: the entry mismatched
//   Locked_out out  high while in lockout
//   busy       out  high while an entry is partly collected, or in
//                   RESULT or LOCKOUT
//   tries_left out  remaining attempts before lockout (0 during lockout)
//
// Every output is a flop. None of them has a combinational path from the
// inputs.
// ----------------------------------------------------------------------------
module serial_code_lock #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1010,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    localparam int                 CW             = $clog2(MAX_TRIES + 1)
) (
    input  logic                clock,
    input  logic                Reset,
    input  logic                B_valid,
    input  logic                B,
    input  logic                load_code,
    input  logic [CODE_LEN-1:0] new_code,
    output logic                Correct,
    output logic                Incorrect,
    output logic                Locked_out,
    output logic                busy,
    output logic [CW-1:0]       tries_left
);

    localparam int BCW = $clog2(CODE_LEN + 1);
    localparam int TW  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [BCW-1:0] LAST_BIT  = BCW'(CODE_LEN - 1);
    localparam logic [CW-1:0]  MAX_FAIL  = CW'(MAX_TRIES);
    localparam logic [TW-1:0]  LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RESULT  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t              state;
    logic [BCW-1:0]      bit_cnt;
    logic                err;
    logic [CW-1:0]       fail_cnt;
    logic [TW-1:0]       lock_tmr;
    logic [CODE_LEN-1:0] code_reg;

    // The expected bit for position k is code_reg[CODE_LEN-1-k]. Shifting
    // the code left by bit_cnt brings that bit to the MSB. This avoids an
    // index wider than the vector.
    logic [CODE_LEN-1:0] code_sh;
    logic                exp_bit;
    logic                bit_miss;
    logic                entry_bad;
    logic [CW-1:0]       fail_inc;

    always_comb begin
        code_sh   = code_reg << bit_cnt;
        exp_bit   = code_sh[CODE_LEN-1];
        bit_miss  = B ^ exp_bit;
        entry_bad = err | bit_miss;
        fail_inc  = fail_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state      <= COLLECT;
            bit_cnt    <= '0;
            err        <= 1'b0;
            fail_cnt   <= '0;
            lock_tmr   <= '0;
            code_reg   <= DEFAULT_CODE;
            Correct    <= 1'b0;
            Incorrect  <= 1'b0;
            Locked_out <= 1'b0;
            busy       <= 1'b0;
            tries_left <= MAX_FAIL;
        end else begin
            // Correct and Incorrect are single-cycle pulses. They default low.
            Correct   <= 1'b0;
            Incorrect <= 1'b0;

            case (state)
                COLLECT: begin
                    if (load_code && (bit_cnt == '0)) begin
                        // A load takes priority over a bit presented on the
                        // same edge. That bit is dropped.
                        code_reg <= new_code;
                    end else if (B_valid) begin
                        if (bit_cnt == LAST_BIT) begin
                            state     <= RESULT;
                            bit_cnt   <= '0;
                            err       <= entry_bad;
                            Correct   <= ~entry_bad;
                            Incorrect <= entry_bad;
                            busy      <= 1'b1;
                            // The fail count is updated while entering
                            // RESULT. tries_left then already shows the
                            // new value during the verdict pulse.
                            if (entry_bad) begin
                                fail_cnt   <= fail_inc;
                                tries_left <= MAX_FAIL - fail_inc;
                            end else begin
                                fail_cnt   <= '0;
                                tries_left <= MAX_FAIL;
                            end
                        end else begin
                            // A mismatch is sticky. The entry still runs to
                            // its full length, so the failing bit is not
                            // revealed early.
                            bit_cnt <= bit_cnt + 1'b1;
                            err     <= entry_bad;
                            busy    <= 1'b1;
                        end
                    end
                end

                RESULT: begin
                    // Bits arriving during the verdict cycle are dropped.
                    err <= 1'b0;
                    if (fail_cnt == MAX_FAIL) begin
                        state      <= LOCKOUT;
                        lock_tmr   <= '0;
                        Locked_out <= 1'b1;
                        tries_left <= '0;
                        busy       <= 1'b1;
                    end else begin
                        state <= COLLECT;
                        busy  <= 1'b0;
                    end
                end

                LOCKOUT: begin
                    // lock_tmr counts 0..LOCKOUT_CYCLES-1. That gives exactly
                    // LOCKOUT_CYCLES cycles with Locked_out high.
                    if (lock_tmr == LOCK_LAST) begin
                        state      <= COLLECT;
                        lock_tmr   <= '0;
                        fail_cnt   <= '0;
                        err        <= 1'b0;
                        Locked_out <= 1'b0;
                        busy       <= 1'b0;
                        tries_left <= MAX_FAIL;
                    end else begin
                        lock_tmr <= lock_tmr + 1'b1;
                    end
                end

                default: begin
                    state      <= COLLECT;
                    bit_cnt    <= '0;
                    err        <= 1'b0;
                    fail_cnt   <= '0;
                    lock_tmr   <= '0;
                    Locked_out <= 1'b0;
                    busy       <= 1'b0;
                    tries_left <= MAX_FAIL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_lock.sv
// ----------------------------------------------------------------------------
// tb_serial_code_lock
//
// Self-checking bench for serial_code_lock with default parameters. Each
// completed entry pushes its expected verdict and tries_left onto a queue.
// A monitor pops the queue whenever the DUT pulses Correct or Incorrect.
// Each scenario task also checks timing, lockout length and reset values
// inline.
// ----------------------------------------------------------------------------
module tb_serial_code_lock;

    localparam int CODE_LEN       = 4;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 16;

    logic       clock = 1'b0;
    logic       Reset;
    logic       B_valid;
    logic       B;
    logic       load_code;
    logic [3:0] new_code;
    logic       Correct;
    logic       Incorrect;
    logic       Locked_out;
    logic       busy;
    logic [1:0] tries_left;

    serial_code_lock #(
        .CODE_LEN      (CODE_LEN),
        .DEFAULT_CODE  (4'b1010),
        .MAX_TRIES     (MAX_TRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clock     (clock),
        .Reset     (Reset),
        .B_valid   (B_valid),
        .B         (B),
        .load_code (load_code),
        .new_code  (new_code),
        .Correct   (Correct),
        .Incorrect (Incorrect),
        .Locked_out(Locked_out),
        .busy      (busy),
        .tries_left(tries_left)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [3:0] m_code;
    int         m_fail;
    logic       exp_lock;

    typedef struct packed {
        logic       c;
        logic [1:0] t;
    } exp_t;
    exp_t sb[$];

    // Verdict monitor: pops one expectation per Correct/Incorrect pulse.
    always @(negedge clock) begin
        exp_t e;
        if (!Reset && (Correct || Incorrect)) begin
            n_total++;
            if ((Correct && Incorrect) || Locked_out) begin
                $display("FAIL exclusive: C=%b I=%b L=%b, required one-hot with L=0",
                         Correct, Incorrect, Locked_out);
            end else begin
                n_pass++;
            end
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_verdict: C=%b I=%b t=%0d, required no verdict",
                         Correct, Incorrect, tries_left);
            end else begin
                e = sb.pop_front();
                if ({Correct, Incorrect, tries_left} !== {e.c, ~e.c, e.t}) begin
                    $display("FAIL verdict: C=%b I=%b t=%0d, required C=%b I=%b t=%0d",
                             Correct, Incorrect, tries_left, e.c, ~e.c, e.t);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic b);
        @(negedge clock);
        B_valid = v;
        B       = b;
    endtask

    // Sends one full entry with random idle gaps of up to maxgap cycles.
    // If mid_load is set, a load is attempted after the second bit.
    task automatic send_entry(input logic [3:0] code, input int maxgap,
                              input logic mid_load, input string name);
        logic c;
        for (int k = 3; k >= 0; k--) begin
            int g;
            g = $urandom_range(maxgap, 0);
            repeat (g) drive(1'b0, 1'b0);
            drive(1'b1, code[k]);
            if (mid_load && k == 2) begin
                @(negedge clock);
                B_valid   = 1'b0;
                load_code = 1'b1;
                new_code  = ~m_code;
                @(negedge clock);
                load_code = 1'b0;
            end
        end
        c = (code == m_code);
        if (c) m_fail = 0;
        else   m_fail++;
        exp_lock = (m_fail == MAX_TRIES);
        sb.push_back('{c: c, t: 2'(MAX_TRIES - m_fail)});
        drive(1'b0, 1'b0);
        n_total++;
        if ((Correct | Incorrect) !== 1'b1) begin
            $display("FAIL %s_timing: C=%b I=%b, required a verdict the cycle after the last bit",
                     name, Correct, Incorrect);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_lockout(input string name);
        int   cnt;
        logic done;
        logic tl_bad;
        cnt    = 0;
        done   = 1'b0;
        tl_bad = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (Locked_out) begin
                cnt++;
                if (tries_left !== 2'd0) tl_bad = 1'b1;
                B_valid = 1'b1;
                B       = 1'($urandom_range(1, 0));
            end else begin
                B_valid = 1'b0;
                if (cnt > 0) done = 1'b1;
            end
        end
        n_total++;
        if (cnt != LOCKOUT_CYCLES) begin
            $display("FAIL %s_len: lockout %0d cycles, required %0d", name, cnt, LOCKOUT_CYCLES);
        end else begin
            n_pass++;
        end
        n_total++;
        if (tl_bad) begin
            $display("FAIL %s_tries: tries_left nonzero during lockout, required 0", name);
        end else begin
            n_pass++;
        end
        n_total++;
        if ({busy, tries_left} !== {1'b0, 2'd3}) begin
            $display("FAIL %s_exit: busy=%b t=%0d, required busy=0 t=3", name, busy, tries_left);
        end else begin
            n_pass++;
        end
        m_fail = 0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        B_valid   = 1'b0;
        B         = 1'b0;
        load_code = 1'b0;
        new_code  = 4'b0000;
        m_code    = 4'b1010;
        m_fail    = 0;
        repeat (2) @(negedge clock);
        n_total++;
        if ({Correct, Incorrect, Locked_out, busy, tries_left} !== {4'b0000, 2'd3}) begin
            $display("FAIL reset: C=%b I=%b L=%b busy=%b t=%0d, required 0 0 0 0 3",
                     Correct, Incorrect, Locked_out, busy, tries_left);
        end else begin
            n_pass++;
        end
        @(negedge clock);
        Reset = 1'b0;
    endtask

    task automatic test_correct();
        send_entry(4'b1010, 0, 1'b0, "correct");
    endtask

    task automatic test_gaps();
        send_entry(4'b1110, 3, 1'b0, "gap_wrong");
        send_entry(4'b1010, 3, 1'b0, "gap_right");
    endtask

    task automatic test_lockout();
        send_entry(4'b0000, 1, 1'b0, "lock1");
        send_entry(4'b1111, 0, 1'b0, "lock2");
        send_entry(4'b0101, 2, 1'b0, "lock3");
        n_total++;
        if (!exp_lock) begin
            $display("FAIL lock_model: fail count %0d, required %0d", m_fail, MAX_TRIES);
        end else begin
            n_pass++;
        end
        check_lockout("lockout");
        send_entry(4'b1010, 0, 1'b0, "after_lock");
    endtask

    task automatic test_fail_clear();
        send_entry(4'b0011, 0, 1'b0, "clr1");
        send_entry(4'b1000, 1, 1'b0, "clr2");
        send_entry(4'b1010, 0, 1'b0, "clr_ok");
        send_entry(4'b0001, 0, 1'b0, "clr3");
        send_entry(4'b1011, 0, 1'b0, "clr4");
        drive(1'b0, 1'b0);
        n_total++;
        if (Locked_out !== 1'b0) begin
            $display("FAIL no_lockout: Locked_out=%b, required 0", Locked_out);
        end else begin
            n_pass++;
        end
        send_entry(4'b1010, 0, 1'b0, "clr_reset");
    endtask

    task automatic test_load();
        // Load while idle, with a simultaneous bit that must be dropped
        @(negedge clock);
        load_code = 1'b1;
        new_code  = 4'b0110;
        B_valid   = 1'b1;
        B         = 1'b0;
        @(negedge clock);
        load_code = 1'b0;
        B_valid   = 1'b0;
        m_code    = 4'b0110;
        send_entry(4'b1010, 0, 1'b0, "load_old");
        send_entry(4'b0110, 1, 1'b0, "load_new");
        // A load attempted in mid-entry is ignored
        send_entry(4'b0110, 0, 1'b1, "load_mid");
        send_entry(4'b0110, 0, 1'b0, "load_kept");
    endtask

    task automatic test_reset_async();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        n_total++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_busy: busy=%b, required 1", busy);
        end else begin
            n_pass++;
        end
        #2 Reset = 1'b1;
        #1;
        n_total++;
        if ({Correct, Incorrect, Locked_out, busy, tries_left} !== {4'b0000, 2'd3}) begin
            $display("FAIL reset_mid: C=%b I=%b L=%b busy=%b t=%0d, required 0 0 0 0 3",
                     Correct, Incorrect, Locked_out, busy, tries_left);
        end else begin
            n_pass++;
        end
        @(negedge clock);
        Reset  = 1'b0;
        m_code = 4'b1010;
        m_fail = 0;

        send_entry(4'b0000, 0, 1'b0, "rl1");
        send_entry(4'b0110, 0, 1'b0, "rl2");
        send_entry(4'b1110, 0, 1'b0, "rl3");
        repeat (5) drive(1'b0, 1'b0);
        n_total++;
        if (Locked_out !== 1'b1) begin
            $display("FAIL rl_locked: Locked_out=%b, required 1", Locked_out);
        end else begin
            n_pass++;
        end
        #2 Reset = 1'b1;
        #1;
        n_total++;
        if ({Correct, Incorrect, Locked_out, busy, tries_left} !== {4'b0000, 2'd3}) begin
            $display("FAIL reset_lock: C=%b I=%b L=%b busy=%b t=%0d, required 0 0 0 0 3",
                     Correct, Incorrect, Locked_out, busy, tries_left);
        end else begin
            n_pass++;
        end
        @(negedge clock);
        Reset  = 1'b0;
        m_fail = 0;
        send_entry(4'b1010, 0, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_correct();
        test_gaps();
        test_lockout();
        test_fail_clear();
        test_load();
        test_reset_async();
        repeat (3) drive(1'b0, 1'b0);
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d verdicts outstanding, required 0", sb.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
